gray_ptr_sync: RTL and testbench
================================

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 Parameter width, default 10, pointer width in bits (FIFO address width + 1).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
REQ-003 Parameter WRITE_SIDE, default 1. 1 = local pointer is the write pointer; 0 = local pointer is the read pointer.
REQ-004 Parameter AF_THRESH, default 2**(width-1)-2, occupancy at which almostFull asserts.
REQ-005 CLK  in  1  sole clock; every register is clocked on its rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 remoteGray  in  width  peer-domain Gray pointer, asynchronous to CLK.
REQ-008 localBin  in  width  local binary pointer, synchronous to CLK.
REQ-009 remoteBin  out  width  synchronized remote pointer in binary.
REQ-010 remoteBin__RDY  out  1  synchronizer pipeline warmed up.
REQ-011 count  out  width  FIFO occupancy as seen from this side.
REQ-012 empty, full, almostFull  out  1 each  status flags.
REQ-013 syncError  out  1  sticky flag: illegal Gray transition or occupancy out of range.
REQ-014 clearError__ENA  in  1  clears syncError; clearError__RDY  out  1, tied to 1.

Function
REQ-015 remoteGray SHALL pass through a SYNC_STAGES-deep flop chain; the output of the last stage is syncGray.
REQ-016 syncGray SHALL be converted Gray-to-binary (b[msb]=g[msb]; b[i]=b[i+1]^g[i]) and registered into remoteBin; latency from a stable remoteGray change to remoteBin is SYNC_STAGES+1 cycles.
REQ-017 remoteBin__RDY SHALL go to 1 exactly SYNC_STAGES+1 cycles after RST deasserts and stay at 1 until the next reset.
REQ-018 count SHALL be combinational from registered remoteBin and live localBin, modulo 2**width: WRITE_SIDE=1 gives localBin-remoteBin; WRITE_SIDE=0 gives remoteBin-localBin.
REQ-019 empty SHALL equal (count==0); full SHALL equal (count==2**(width-1)); almostFull SHALL equal (count>=AF_THRESH).
REQ-020 Flags SHALL respond to a localBin change in the same cycle (zero latency), so that the local side never over-runs or under-runs.
REQ-021 While remoteBin__RDY=0, full SHALL be forced to 1 when WRITE_SIDE=1, and empty SHALL be forced to 1 when WRITE_SIDE=0.
REQ-022 A previous-sample register SHALL hold the last syncGray value; popcount(syncGray ^ previous) > 1 while remoteBin__RDY=1 SHALL set syncError on the next edge.
REQ-023 count > 2**(width-1) while remoteBin__RDY=1 SHALL set syncError on the next edge.
REQ-024 syncError SHALL clear on the edge where clearError__ENA=1; if set and clear occur in the same cycle, set wins.
REQ-025 Pointer wrap-around (all-ones to zero in binary; the corresponding single-bit Gray step) SHALL be treated as legal and SHALL produce correct count.

Reset
REQ-026 On RST=1, all sync stages, the previous-sample register, remoteBin, remoteBin__RDY and syncError SHALL go to 0 immediately, without waiting for a clock edge.
REQ-027 After reset with localBin=0: count=0, empty=1, almostFull=0, full=1 when WRITE_SIDE=1 (per REQ-021) or 0 otherwise.
REQ-028 RST asserted mid-operation SHALL discard all in-flight samples; the warm-up of REQ-017 restarts.

Structure
REQ-029 A shared package gray_pkg SHALL hold the gray2bin and bin2gray functions and a onehot-or-zero check function; no module-local copies.
REQ-030 The flop chain SHALL be a sub-module sync_chain (parameters width, SYNC_STAGES; ports CLK, RST, d, q), instantiated once.
REQ-031 No combinational logic SHALL sit between remoteGray and the first sync flop.

Verification
REQ-032 Reset release, remoteGray=0, localBin=0, WRITE_SIDE=1 -> remoteBin__RDY rises on cycle 3 (SYNC_STAGES=2); full=1 until then, then full=0, empty=1.
REQ-033 WRITE_SIDE=1, width=4, localBin stepped 0..8, remoteGray held 0 -> count 0..8; almostFull at 6; full at 8; syncError stays 0.
REQ-034 remoteGray stepped through Gray 0..15 and wrapped to 0, localBin tracking -> remoteBin follows with 3-cycle latency, count correct across wrap, no syncError.
REQ-035 remoteGray jumps 0000 -> 0011 -> syncError=1 three cycles later and sticky; clearError__ENA pulse -> 0; set coincident with clear -> stays 1.
REQ-036 WRITE_SIDE=0: remoteGray = gray(5), localBin=5 -> empty=1; localBin=3 -> count=2, empty=0; RST pulse mid-stream -> remoteBin=0 and remoteBin__RDY=0 immediately.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg -- shared helpers for Gray-coded FIFO pointer handling.
//   bin2gray / gray2bin : conversions on a word of up to GP_MAXW bits.
//                         Zero-extended narrower pointers convert correctly,
//                         because leading zeros stay zeros in both directions.
//   onehot0             : true when at most one bit of the argument is set.
//   ptr_flags_t         : occupancy status bundle used by gray_ptr_sync.
package gray_pkg;

  localparam int GP_MAXW = 32;

  typedef logic [GP_MAXW-1:0] gp_word_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
  } ptr_flags_t;

  function automatic gp_word_t bin2gray(input gp_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gp_word_t gray2bin(input gp_word_t g);
    gp_word_t b;
    b[GP_MAXW-1] = g[GP_MAXW-1];
    for (int i = GP_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic onehot0(input gp_word_t v);
    return (v & (v - gp_word_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain -- plain multi-flop synchronizer for a Gray-coded bus.
//   CLK : destination clock
//   RST : asynchronous active-high reset, clears every stage
//   d   : asynchronous input, lands directly on the first flop
//   q   : output of the last stage
module sync_chain #(
  parameter int width       = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [SYNC_STAGES-1:0][width-1:0] stg_q, stg_d;

  // Stage 0 takes d with nothing in front of it; later stages shift.
  always_comb begin
    stg_d = {stg_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stg_q <= '0;
    else     stg_q <= stg_d;
  end

  assign q = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// gray_ptr_sync -- brings the peer-domain Gray pointer of an async FIFO into
// the local clock domain and derives occupancy and status flags.
//   CLK, RST          : local clock, asynchronous active-high reset
//   remoteGray        : peer Gray pointer (asynchronous to CLK)
//   localBin          : local binary pointer (synchronous to CLK)
//   remoteBin         : synchronized peer pointer, binary, registered
//   remoteBin__RDY    : synchronizer warmed up after reset
//   count             : occupancy seen from this side (mod 2**width)
//   empty/full/almostFull : status flags, live on localBin
//   syncError         : sticky; illegal Gray step or occupancy out of range
//   clearError__ENA/RDY : clears syncError (RDY always 1)
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int width       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int WRITE_SIDE  = 1,
  parameter int AF_THRESH   = 2**(width-1) - 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] remoteGray,
  input  logic [width-1:0] localBin,
  output logic [width-1:0] remoteBin,
  output logic             remoteBin__RDY,
  output logic [width-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almostFull,
  output logic             syncError,
  input  logic             clearError__ENA,
  output logic             clearError__RDY
);

  localparam logic [width-1:0] HALF = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] AF_T = width'(AF_THRESH);

  logic [width-1:0]     sync_gray;
  logic [width-1:0]     prev_q, prev_d;
  logic [width-1:0]     rbin_q, rbin_d;
  logic [SYNC_STAGES:0] vld_pipe_q, vld_pipe_d;
  logic                 err_q, err_d;
  logic                 rdy;
  logic [width-1:0]     cnt;
  logic                 gray_bad, occ_bad;
  ptr_flags_t           flg;

  sync_chain #(.width(width), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (remoteGray),
    .q   (sync_gray)
  );

  // Warm-up: a 1 walks up the shift register; its top bit is the ready flag,
  // reaching it SYNC_STAGES+1 edges after reset, same as the data latency.
  assign rdy = vld_pipe_q[SYNC_STAGES];

  always_comb begin
    prev_d     = sync_gray;
    rbin_d     = width'(gray2bin(gp_word_t'(sync_gray)));
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};

    // Uses the live local pointer so flags never lag the local side.
    if (WRITE_SIDE != 0) cnt = localBin - rbin_q;
    else                 cnt = rbin_q - localBin;

    gray_bad = !onehot0(gp_word_t'(sync_gray ^ prev_q));
    occ_bad  = cnt > HALF;

    // Set dominates clear.
    err_d = (rdy & (gray_bad | occ_bad)) | (err_q & ~clearError__ENA);

    // Until warmed up, block the local side: writer sees full, reader empty.
    flg.empty       = (cnt == '0)  | (~rdy & (WRITE_SIDE == 0));
    flg.full        = (cnt == HALF) | (~rdy & (WRITE_SIDE != 0));
    flg.almost_full = cnt >= AF_T;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prev_q     <= '0;
      rbin_q     <= '0;
      vld_pipe_q <= '0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      rbin_q     <= rbin_d;
      vld_pipe_q <= vld_pipe_d;
      err_q      <= err_d;
    end
  end

  assign remoteBin       = rbin_q;
  assign remoteBin__RDY  = rdy;
  assign count           = cnt;
  assign empty           = flg.empty;
  assign full            = flg.full;
  assign almostFull      = flg.almost_full;
  assign syncError       = err_q;
  assign clearError__RDY = 1'b1;

endmodule

// File: tb/tb_gray_ptr_sync.sv
module tb_gray_ptr_sync;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] remoteGray, localW, localR;
  logic         clr;

  logic [W-1:0] rbW, cntW, rbR, cntR;
  logic         rdyW, emW, fuW, afW, erW, crW;
  logic         rdyR, emR, fuR, afR, erR, crR;

  always #5 CLK = ~CLK;

  gray_ptr_sync #(.width(W), .SYNC_STAGES(2), .WRITE_SIDE(1)) dut_w (
    .CLK(CLK), .RST(RST), .remoteGray(remoteGray), .localBin(localW),
    .remoteBin(rbW), .remoteBin__RDY(rdyW), .count(cntW), .empty(emW),
    .full(fuW), .almostFull(afW), .syncError(erW),
    .clearError__ENA(clr), .clearError__RDY(crW)
  );

  gray_ptr_sync #(.width(W), .SYNC_STAGES(2), .WRITE_SIDE(0)) dut_r (
    .CLK(CLK), .RST(RST), .remoteGray(remoteGray), .localBin(localR),
    .remoteBin(rbR), .remoteBin__RDY(rdyR), .count(cntR), .empty(emR),
    .full(fuR), .almostFull(afR), .syncError(erR),
    .clearError__ENA(clr), .clearError__RDY(crR)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
    end
  endtask

  // Reference conversions from the definition of reflected binary code.
  function automatic logic [W-1:0] g_of(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] b_of(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 2**W; k++)
      if (g_of(W'(k)) == g) r = W'(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: the driver pushes each remote pointer it applies; the monitor
  // expects it on remoteBin three edges later and checks occupancy flags.
  typedef struct {
    logic [W-1:0] ptr;
    int           c;
  } item_t;

  item_t exp_q[$];
  bit    mon_en = 1'b0;

  always @(negedge CLK) begin : mon
    item_t        it;
    logic [W-1:0] ew, er;
    if (mon_en && rdyW && exp_q.size() > 0 && exp_q[0].c + 3 <= cyc) begin
      it = exp_q.pop_front();
      ew = localW - it.ptr;
      er = it.ptr - localR;
      chk("sb_age",    32'(cyc - it.c), 32'(3));
      chk("sb_rbin_w", 32'(rbW),  32'(it.ptr));
      chk("sb_rbin_r", 32'(rbR),  32'(it.ptr));
      chk("sb_cnt_w",  32'(cntW), 32'(ew));
      chk("sb_em_w",   32'(emW),  32'(ew == 0));
      chk("sb_fu_w",   32'(fuW),  32'(ew == 8));
      chk("sb_af_w",   32'(afW),  32'(ew >= 6));
      chk("sb_err_w",  32'(erW),  32'(0));
      chk("sb_cnt_r",  32'(cntR), 32'(er));
      chk("sb_em_r",   32'(emR),  32'(er == 0));
      chk("sb_fu_r",   32'(fuR),  32'(er == 8));
      chk("sb_err_r",  32'(erR),  32'(0));
    end
  end

  initial begin
    logic [W-1:0] ptr, lag, g1, g2, nb1, nb2;
    logic [W-1:0] lagq[$];
    int           step;

    RST = 1'b1; remoteGray = '0; localW = '0; localR = '0; clr = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rbin",  32'(rbW),  32'(0));
    chk("rst_rdy",   32'(rdyW), 32'(0));
    chk("rst_cnt",   32'(cntW), 32'(0));
    chk("rst_em_w",  32'(emW),  32'(1));
    chk("rst_fu_w",  32'(fuW),  32'(1));
    chk("rst_af_w",  32'(afW),  32'(0));
    chk("rst_err",   32'(erW),  32'(0));
    chk("rst_fu_r",  32'(fuR),  32'(0));
    chk("rst_em_r",  32'(emR),  32'(1));
    chk("clr_rdy",   32'(crW),  32'(1));

    // Warm-up after reset release.
    tick(); RST = 1'b0;
    @(negedge CLK);
    chk("warm_c0", 32'(rdyW), 32'(0));
    for (int n = 1; n <= 4; n++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("warm_rdy_c%0d", n), 32'(rdyW), 32'(n >= 3));
      chk($sformatf("warm_fu_c%0d", n),  32'(fuW),  32'(n < 3));
      chk($sformatf("warm_em_c%0d", n),  32'(emW),  32'(1));
    end

    // Local pointer stepping with the remote pointer parked at zero.
    for (int l = 0; l <= 8; l++) begin
      tick(); localW = W'(l);
      @(negedge CLK);
      chk($sformatf("step_cnt_%0d", l), 32'(cntW), 32'(l));
      chk($sformatf("step_af_%0d", l),  32'(afW),  32'(l >= 6));
      chk($sformatf("step_fu_%0d", l),  32'(fuW),  32'(l == 8));
      chk($sformatf("step_em_%0d", l),  32'(emW),  32'(l == 0));
      chk($sformatf("step_err_%0d", l), 32'(erW),  32'(0));
    end
    tick(); localW = '0;
    @(negedge CLK);
    chk("full_no_err", 32'(erW), 32'(0));

    // Remote walk: a directed wrap first, then random legal advances.
    ptr = '0;
    lagq = '{W'(0), W'(0), W'(0)};
    mon_en = 1'b1;
    for (int i = 0; i < 220; i++) begin
      tick();
      if (i < 20)       step = 1;
      else if (i >= 216) step = 0;
      else              step = int'($urandom_range(0, 1));
      ptr = ptr + W'(step);
      remoteGray = g_of(ptr);
      exp_q.push_back('{ptr: ptr, c: cyc});
      lagq.push_back(ptr);
      lag = lagq.pop_front();
      localW = lag + W'($urandom_range(0, 8));
      localR = lag - W'($urandom_range(0, 8));
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    mon_en = 1'b0;
    chk("sb_drained", 32'(exp_q.size()), 32'(0));

    // Illegal two-bit Gray jump.
    tick(); localW = ptr; localR = ptr;
    g1  = g_of(ptr) ^ 4'b0011;
    nb1 = b_of(g1);
    tick(); remoteGray = g1;
    @(negedge CLK);
    chk("jump_c0", 32'(erW), 32'(0));
    @(posedge CLK); @(negedge CLK);
    chk("jump_c1", 32'(erW), 32'(0));
    @(posedge CLK); @(negedge CLK);
    chk("jump_c2", 32'(erW), 32'(0));
    @(posedge CLK); #1; localW = nb1; localR = nb1;
    @(negedge CLK);
    chk("jump_c3_w", 32'(erW), 32'(1));
    chk("jump_c3_r", 32'(erR), 32'(1));
    chk("jump_rbin", 32'(rbW), 32'(nb1));
    repeat (2) begin
      @(posedge CLK); @(negedge CLK);
      chk("jump_sticky", 32'(erW), 32'(1));
    end
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge CLK);
    chk("clear_w", 32'(erW), 32'(0));
    chk("clear_r", 32'(erR), 32'(0));

    // Set coincident with clear: set must win.
    g2  = g1 ^ 4'b0011;
    nb2 = b_of(g2);
    tick(); remoteGray = g2;
    tick();
    tick(); clr = 1'b1;
    tick(); clr = 1'b0; localW = nb2; localR = nb2;
    @(negedge CLK);
    chk("set_wins_w", 32'(erW), 32'(1));
    chk("set_wins_r", 32'(erR), 32'(1));
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge CLK);
    chk("clear2", 32'(erW), 32'(0));

    // Occupancy one past half range.
    tick(); localW = nb2 + W'(9);
    tick(); localW = nb2;
    @(negedge CLK);
    chk("occ_err_w", 32'(erW), 32'(1));
    chk("occ_err_r", 32'(erR), 32'(0));
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge CLK);
    chk("occ_clear", 32'(erW), 32'(0));

    // Read side.
    tick(); remoteGray = g_of(W'(5)); localW = W'(5); localR = W'(5);
    repeat (5) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge CLK);
    chk("rd_em",   32'(emR),  32'(1));
    chk("rd_cnt",  32'(cntR), 32'(0));
    chk("rd_rbin", 32'(rbR),  32'(5));
    chk("rd_err",  32'(erR),  32'(0));
    tick(); localR = W'(3);
    @(negedge CLK);
    chk("rd_cnt2", 32'(cntR), 32'(2));
    chk("rd_em2",  32'(emR),  32'(0));

    // Reset mid-stream acts without a clock edge.
    @(posedge CLK); #2; RST = 1'b1; #1;
    chk("mrst_rbin_r", 32'(rbR),  32'(0));
    chk("mrst_rdy_r",  32'(rdyR), 32'(0));
    chk("mrst_em_r",   32'(emR),  32'(1));
    chk("mrst_rbin_w", 32'(rbW),  32'(0));
    chk("mrst_fu_w",   32'(fuW),  32'(1));
    tick(); tick(); RST = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge CLK); @(negedge CLK);
      chk($sformatf("rewarm_rdy_c%0d", n), 32'(rdyR), 32'(n >= 3));
      chk($sformatf("rewarm_em_c%0d", n),  32'(emR),  32'(n < 3));
    end
    chk("rewarm_cnt", 32'(cntR), 32'(2));
    chk("rewarm_err", 32'(erR),  32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
